// File: rtl/fetch_queue_stage_pkg.sv
// Shared fetch-pipeline definitions: default widths and the buffered fetch entry.
package fetch_queue_stage_pkg;

  localparam int FQ_PC_W    = 6;
  localparam int FQ_INSTR_W = 32;
  localparam int FQ_DEPTH   = 4;

  // One buffered fetch result: the word and the PC it was fetched from.
  // The pc field occupies the upper bits when the struct is packed.
  typedef struct packed {
    logic [FQ_PC_W-1:0]    pc;
    logic [FQ_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_stage_if.sv
// Fetch-stage bus bundle.
// Groups two things: the instruction-memory port, and the redirect and decode
// handshake signals.
// master = fetch stage, slave = its environment (memory, decode, branch unit).
interface fetch_queue_stage_if
  import fetch_queue_stage_pkg::*;
#(
  parameter int PC_W    = FQ_PC_W,
  parameter int INSTR_W = FQ_INSTR_W
);

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_q;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               id_valid;
  logic               id_ready;
  logic [INSTR_W-1:0] id_instr;
  logic [PC_W-1:0]    id_pc;
  logic [PC_W-1:0]    id_pc_plus1;

  modport master (
    output imem_addr,
    input  imem_q,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    input  id_ready,
    output id_instr,
    output id_pc,
    output id_pc_plus1
  );

  modport slave (
    input  imem_addr,
    output imem_q,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    output id_ready,
    input  id_instr,
    input  id_pc,
    input  id_pc_plus1
  );

endinterface

// File: rtl/fetch_queue_stage_fifo.sv
// Small circular FIFO for fetched entries.
// Supports push, pop and flush, and exposes the head combinationally.
// Storage is reset as well so the head reads as zero straight out of reset.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 38
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointer and occupancy tracking; flush wins over any push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage written at the write pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end.
// Owns the fetch PC and issues one memory read per cycle while there is
// credit. Returned words are queued with their PCs and presented to decode
// over valid/ready. A redirect flushes the queue and any read still in flight.
module fetch_queue_stage
  import fetch_queue_stage_pkg::*;
#(
  parameter int PC_W    = FQ_PC_W,
  parameter int INSTR_W = FQ_INSTR_W,
  parameter int DEPTH   = FQ_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  fetch_queue_stage_if.master bus
);

  localparam int ENTRY_W = PC_W + INSTR_W;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic [PC_W-1:0]    fetch_pc_q;
  logic [PC_W-1:0]    inflight_pc_q;
  logic               inflight_q;
  logic [CNT_W-1:0]   count;
  logic [CNT_W:0]     credit_sum;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic               issue;
  logic               push;
  logic               pop;
  logic               flush;
  logic               id_valid;

  // Credit check: buffered plus in-flight entries must leave room for one more.
  // A pop in the same cycle earns no credit.
  always_comb begin
    credit_sum = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
    issue      = !bus.redirect_valid && (credit_sum < (CNT_W+1)'(DEPTH));
  end

  assign flush     = bus.redirect_valid;
  assign push      = inflight_q && !bus.redirect_valid;
  assign id_valid  = (count != '0);
  assign pop       = id_valid && bus.id_ready;
  assign push_data = {inflight_pc_q, bus.imem_q};

  // Fetch PC and in-flight tracking.
  // A redirect restarts fetch and kills the outstanding read by clearing inflight_q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc_q <= bus.redirect_pc;
      inflight_q <= 1'b0;
    end else if (issue) begin
      inflight_q    <= 1'b1;
      inflight_pc_q <= fetch_pc_q;
      fetch_pc_q    <= fetch_pc_q + PC_W'(1);
    end else begin
      inflight_q <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_data),
    .head_data (head_data),
    .count     (count)
  );

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.id_valid    = id_valid;
  assign bus.id_instr    = head_data[INSTR_W-1:0];
  assign bus.id_pc       = head_data[ENTRY_W-1 -: PC_W];
  assign bus.id_pc_plus1 = head_data[ENTRY_W-1 -: PC_W] + PC_W'(1);

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Self-checking bench for fetch_queue_stage.
// The expected delivery stream is a plain PC sequence starting at the last
// redirect target, or at 0 after reset. A monitor checks every accepted
// transfer against it.
module tb_fetch_queue_stage;
  import fetch_queue_stage_pkg::*;

  logic clk;
  logic rst;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  fetch_entry_t expQ[$];
  logic         pendValid = 1'b0;
  logic [5:0]   pendPc    = '0;

  fetch_queue_stage_if #(.PC_W(FQ_PC_W), .INSTR_W(FQ_INSTR_W)) bus ();

  fetch_queue_stage #(.PC_W(FQ_PC_W), .INSTR_W(FQ_INSTR_W), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: the word is 0xA000_0000 plus its address.
  always @(posedge clk) bus.imem_q <= 32'hA000_0000 + {26'd0, bus.imem_addr};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference stream: consecutive PCs modulo 64, each paired with its memory word.
  task automatic loadStream(input int start);
    fetch_entry_t e;
    expQ.delete();
    for (int i = 0; i < 400; i++) begin
      e.pc    = 6'((start + i) % 64);
      e.instr = 32'hA000_0000 + 32'((start + i) % 64);
      expQ.push_back(e);
    end
  endtask

  // Drive one cycle of inputs just after the edge.
  // A redirect driven in the previous cycle takes effect in the model here.
  // That keeps a same-cycle pop from the old stream checked against the old stream.
  task automatic applyStimulus(input logic rdy, input logic rv, input logic [5:0] rpc);
    @(posedge clk);
    #1;
    if (pendValid) begin
      loadStream(int'(pendPc));
      pendValid = 1'b0;
    end
    bus.id_ready       = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    if (rv) begin
      pendValid = 1'b1;
      pendPc    = rpc;
    end
  endtask

  task automatic doReset();
    rst                = 1'b0;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    #1;
    checkOutput("rst_id_valid",  64'(bus.id_valid),  64'd0);
    checkOutput("rst_imem_addr", 64'(bus.imem_addr), 64'd0);
    checkOutput("rst_id_pc",     64'(bus.id_pc),     64'd0);
    checkOutput("rst_id_instr",  64'(bus.id_instr),  64'd0);
    repeat (2) @(posedge clk);
    #1;
    pendValid = 1'b0;
    loadStream(0);
    rst = 1'b1;
  endtask

  // Scoreboard monitor: every accepted transfer must match the next expected entry.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (rst === 1'b1 && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
      xfers++;
      if (expQ.size() == 0) begin
        checkOutput("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("sb_id_pc",       64'(bus.id_pc),       64'(e.pc));
        checkOutput("sb_id_instr",    64'(bus.id_instr),    64'(e.instr));
        checkOutput("sb_id_pc_plus1", 64'(bus.id_pc_plus1), 64'((int'(e.pc) + 1) % 64));
      end
    end
  end

  initial begin
    rst                = 1'b1;
    bus.id_ready       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    // Fill latency and free-running delivery.
    doReset();
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("fill_valid_e1", 64'(bus.id_valid),  64'd0);
    checkOutput("fill_addr_e1",  64'(bus.imem_addr), 64'd1);
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("fill_valid_e2", 64'(bus.id_valid),  64'd1);
    checkOutput("fill_pc_e2",    64'(bus.id_pc),     64'd0);
    checkOutput("fill_instr_e2", 64'(bus.id_instr),  64'hA000_0000);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd0);
      checkOutput("stream_valid", 64'(bus.id_valid), 64'd1);
    end

    // Backpressure: the queue saturates and fetch stops at PC 4.
    doReset();
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 6'd0);
    checkOutput("bp_addr",  64'(bus.imem_addr), 64'd4);
    checkOutput("bp_valid", 64'(bus.id_valid),  64'd1);
    checkOutput("bp_pc",    64'(bus.id_pc),     64'd0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd0);
      checkOutput("bp_release_valid", 64'(bus.id_valid), 64'd1);
    end

    // Redirect with three buffered entries and one read in flight.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 6'd0);
    applyStimulus(1'b0, 1'b1, 6'h20);
    checkOutput("rd_pre_valid", 64'(bus.id_valid), 64'd1);
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("rd_valid_e1", 64'(bus.id_valid),  64'd0);
    checkOutput("rd_addr_e1",  64'(bus.imem_addr), 64'h20);
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("rd_valid_e2", 64'(bus.id_valid),  64'd0);
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("rd_valid_e3", 64'(bus.id_valid),  64'd1);
    checkOutput("rd_pc_e3",    64'(bus.id_pc),     64'h20);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 6'd0);

    // Redirect near the top of the address space to exercise wraparound.
    applyStimulus(1'b1, 1'b1, 6'h3E);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 6'd0);

    // Random decode backpressure with back-to-back redirects.
    for (int i = 0; i < 200; i++) begin
      if (i == 50)      applyStimulus(1'($urandom_range(0, 1)), 1'b1, 6'h10);
      else if (i == 51) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 6'h30);
      else              applyStimulus(1'($urandom_range(0, 1)), 1'b0, 6'd0);
    end
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 6'd0);

    // Asynchronous reset in the middle of a cycle with a full queue.
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 6'd0);
    checkOutput("ar_full_valid", 64'(bus.id_valid), 64'd1);
    @(posedge clk);
    #3;
    doReset();
    applyStimulus(1'b1, 1'b0, 6'd0);
    applyStimulus(1'b1, 1'b0, 6'd0);
    checkOutput("ar_restart_valid", 64'(bus.id_valid), 64'd1);
    checkOutput("ar_restart_pc",    64'(bus.id_pc),    64'd0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 6'd0);

    checkOutput("xfer_volume", 64'(xfers >= 100), 64'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
